hls_deadlock_report_ctrl: RTL and testbench

Sequencing controller that sits behind the per-dataflow deadlock monitor. It qualifies the monitor's raw one-cycle `block` indication over a programmable confirmation window and captures a snapshot of which processes were stopped, and why. It delivers that snapshot once over a valid/ready report channel, then holds a sticky `deadlock` flag until software clears it. Raw blocks that do not persist are counted as glitches and then discarded.

---
 rtl/hls_deadlock_report_ctrl_if.sv | 28 ++
 rtl/hls_deadlock_report_ctrl.sv | 151 +++++++++++++++
 tb/tb_hls_deadlock_report_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_deadlock_report_ctrl_if.sv
// Report channel of the deadlock report controller: valid/ready handshake carrying
// the captured stop/axis snapshot and its blocked-process popcount.
interface hls_deadlock_report_ctrl_if #(
  parameter int unsigned N_PROC = 12,
  parameter int unsigned NBLK_W = $clog2(N_PROC + 1)
);
  logic              report_valid;
  logic              report_ready;
  logic [N_PROC-1:0] report_stop_vec;
  logic [N_PROC-1:0] report_axis_vec;
  logic [NBLK_W-1:0] report_nblk;

  modport master (
    output report_valid,
    output report_stop_vec,
    output report_axis_vec,
    output report_nblk,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_stop_vec,
    input  report_axis_vec,
    input  report_nblk,
    output report_ready
  );
endinterface

// File: rtl/hls_deadlock_report_ctrl.sv
// Qualifies the deadlock monitor's raw block over a confirmation window, captures a
// snapshot of the stopped processes, reports it once and holds a sticky deadlock flag.
module hls_deadlock_report_ctrl #(
  parameter int unsigned N_PROC         = 12,
  parameter int unsigned CONFIRM_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               clear,
  input  logic                               raw_block,
  input  logic [N_PROC-1:0]                  idle_vec,
  input  logic [N_PROC-1:0]                  chan_block_vec,
  input  logic [N_PROC-1:0]                  axis_block_vec,
  hls_deadlock_report_ctrl_if.master         rpt,
  output logic                               deadlock,
  output logic [2:0]                         state,
  output logic [7:0]                         glitch_count,
  output logic [7:0]                         report_count
);

  localparam int unsigned NBLK_W = $clog2(N_PROC + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CONFIRM_CYCLES - 1);

  typedef enum logic [2:0] {
    StDisarmed = 3'd0,
    StArmed    = 3'd1,
    StConfirm  = 3'd2,
    StReport   = 3'd3,
    StHold     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        glitch_q, glitch_d;
  logic [7:0]        rcount_q, rcount_d;
  logic              valid_q, valid_d;
  logic              dead_q, dead_d;
  logic [N_PROC-1:0] stop_q, stop_d;
  logic [N_PROC-1:0] axis_q, axis_d;
  logic [NBLK_W-1:0] nblk_q, nblk_d;
  logic              capture;
  logic [N_PROC-1:0] blk_vec;
  logic [NBLK_W-1:0] blk_count;

  assign blk_vec = chan_block_vec | axis_block_vec;

  always_comb begin
    blk_count = '0;
    for (int i = 0; i < int'(N_PROC); i++) begin
      blk_count = blk_count + NBLK_W'(blk_vec[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    rcount_d = rcount_q;
    capture  = 1'b0;
    unique case (state_q)
      StDisarmed: begin
        if (enable) state_d = StArmed;
      end
      StArmed: begin
        if (!enable) begin
          state_d = StDisarmed;
          cnt_d   = '0;
        end else if (raw_block) begin
          state_d = StConfirm;
          cnt_d   = CNT_W'(1);
        end
      end
      StConfirm: begin
        if (!enable) begin
          state_d = StDisarmed;
          cnt_d   = '0;
        end else if (!raw_block) begin
          state_d = StArmed;
          cnt_d   = '0;
          if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end else if (cnt_q == CntLast) begin
          state_d = StReport;
          cnt_d   = '0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StReport: begin
        // clear wins over a same-cycle handshake; enable alone cannot abort
        if (clear) begin
          state_d = enable ? StArmed : StDisarmed;
        end else if (rpt.report_ready) begin
          state_d = StHold;
          if (rcount_q != 8'hFF) rcount_d = rcount_q + 8'd1;
        end
      end
      StHold: begin
        if (clear) state_d = enable ? StArmed : StDisarmed;
      end
      default: begin
        state_d = StDisarmed;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = (state_d == StReport);
    dead_d  = (state_d == StReport) || (state_d == StHold);
    stop_d  = capture ? (idle_vec | blk_vec) : stop_q;
    axis_d  = capture ? axis_block_vec : axis_q;
    nblk_d  = capture ? blk_count : nblk_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StDisarmed;
      cnt_q    <= '0;
      glitch_q <= '0;
      rcount_q <= '0;
      valid_q  <= 1'b0;
      dead_q   <= 1'b0;
      stop_q   <= '0;
      axis_q   <= '0;
      nblk_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      rcount_q <= rcount_d;
      valid_q  <= valid_d;
      dead_q   <= dead_d;
      stop_q   <= stop_d;
      axis_q   <= axis_d;
      nblk_q   <= nblk_d;
    end
  end

  assign rpt.report_valid    = valid_q;
  assign rpt.report_stop_vec = stop_q;
  assign rpt.report_axis_vec = axis_q;
  assign rpt.report_nblk     = nblk_q;
  assign deadlock            = dead_q;
  assign state               = state_q;
  assign glitch_count        = glitch_q;
  assign report_count        = rcount_q;

endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
// Bench for hls_deadlock_report_ctrl: directed scenarios plus random stimulus, all
// checked each cycle against a streak-based behavioural model.
module tb_hls_deadlock_report_ctrl;
  localparam int unsigned NP = 12;
  localparam int unsigned CC = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          raw_block = 1'b0;
  logic [NP-1:0] idle_vec = '0;
  logic [NP-1:0] chan_block_vec = '0;
  logic [NP-1:0] axis_block_vec = '0;
  logic          deadlock;
  logic [2:0]    state;
  logic [7:0]    glitch_count;
  logic [7:0]    report_count;

  hls_deadlock_report_ctrl_if #(.N_PROC(NP)) rpt ();

  hls_deadlock_report_ctrl #(
    .N_PROC        (NP),
    .CONFIRM_CYCLES(CC),
    .CNT_W         (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .raw_block     (raw_block),
    .idle_vec      (idle_vec),
    .chan_block_vec(chan_block_vec),
    .axis_block_vec(axis_block_vec),
    .rpt           (rpt),
    .deadlock      (deadlock),
    .state         (state),
    .glitch_count  (glitch_count),
    .report_count  (report_count)
  );

  always #5 clock = ~clock;

  // Model: watching flag plus the length of the current raw_block streak.
  bit            m_watch;
  int            m_streak;
  bit            m_valid;
  bit            m_dead;
  logic [NP-1:0] m_stop;
  logic [NP-1:0] m_axis;
  int            m_nblk;
  int            m_glitch;
  int            m_rcount;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  function automatic int m_state();
    if (m_dead) return m_valid ? 3 : 4;
    if (m_watch) return (m_streak > 0) ? 2 : 1;
    return 0;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_watch = 0; m_streak = 0; m_valid = 0; m_dead = 0;
      m_stop = '0; m_axis = '0; m_nblk = 0; m_glitch = 0; m_rcount = 0;
    end else if (m_dead) begin
      if (clear) begin
        m_dead = 0; m_valid = 0; m_watch = enable; m_streak = 0;
      end else if (m_valid && rpt.report_ready) begin
        m_valid = 0;
        if (m_rcount < 255) m_rcount++;
      end
    end else if (!m_watch) begin
      m_watch = enable;
    end else if (!enable) begin
      m_watch = 0; m_streak = 0;
    end else if (m_streak == 0) begin
      if (raw_block) m_streak = 1;
    end else if (!raw_block) begin
      m_streak = 0;
      if (m_glitch < 255) m_glitch++;
    end else if (m_streak == int'(CC) - 1) begin
      m_stop   = idle_vec | chan_block_vec | axis_block_vec;
      m_axis   = axis_block_vec;
      m_nblk   = $countones(chan_block_vec | axis_block_vec);
      m_dead   = 1; m_valid = 1; m_streak = 0;
    end else begin
      m_streak++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #2;
  endtask

  task automatic run_raw(input int n);
    raw_block = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        check("state", 32'(state), 32'(m_state()));
        check("report_valid", 32'(rpt.report_valid), 32'(m_valid));
        check("deadlock", 32'(deadlock), 32'(m_dead));
        check("glitch_count", 32'(glitch_count), 32'(m_glitch));
        check("report_count", 32'(report_count), 32'(m_rcount));
        check("report_stop_vec", 32'(rpt.report_stop_vec), 32'(m_stop));
        check("report_axis_vec", 32'(rpt.report_axis_vec), 32'(m_axis));
        check("report_nblk", 32'(rpt.report_nblk), 32'(m_nblk));
      end
    end
  end

  initial begin
    bit seen_valid;
    rpt.report_ready = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_model_state", 32'(m_state()), 32'd0);
    check("rst_valid", 32'(rpt.report_valid), 32'd0);
    check("rst_counts", {16'd0, glitch_count, report_count}, 32'd0);

    // Detection latency and snapshot contents.
    reset = 1'b0; enable = 1'b1;
    tick();
    check("armed", 32'(state), 32'd1);
    chan_block_vec = 12'h0F0; axis_block_vec = 12'h006; idle_vec = 12'hF09;
    raw_block = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) check("lat_valid_low", 32'(rpt.report_valid), 32'd0);
    end
    check("lat_valid_high", 32'(rpt.report_valid), 32'd1);
    check("lat_model_valid", 32'(m_valid), 32'd1);
    check("lit_stop", 32'(rpt.report_stop_vec), 32'hFFF);
    check("lit_axis", 32'(rpt.report_axis_vec), 32'h006);
    check("lit_nblk", 32'(rpt.report_nblk), 32'd6);
    check("lit_model_nblk", 32'(m_nblk), 32'd6);

    // Back-pressure: data must hold while ready is low.
    chan_block_vec = '0; axis_block_vec = '0; idle_vec = '0; raw_block = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_stop_stable", 32'(rpt.report_stop_vec), 32'hFFF);
      check("bp_valid_held", 32'(rpt.report_valid), 32'd1);
    end
    rpt.report_ready = 1'b1;
    tick();
    rpt.report_ready = 1'b0;
    check("hs_state_hold", 32'(state), 32'd4);
    check("hs_valid_low", 32'(rpt.report_valid), 32'd0);
    check("hs_count", 32'(report_count), 32'd1);
    for (int i = 0; i < 50; i++) begin
      raw_block = ~raw_block;
      tick();
      check("hold_deadlock", 32'(deadlock), 32'd1);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_deadlock", 32'(deadlock), 32'd0);
    check("clear_to_armed", 32'(state), 32'd1);

    // clear and ready together in REPORT.
    run_raw(4);
    check("cr_in_report", 32'(state), 32'd3);
    clear = 1'b1; rpt.report_ready = 1'b1;
    tick();
    clear = 1'b0; rpt.report_ready = 1'b0;
    check("cr_state", 32'(state), 32'd1);
    check("cr_count", 32'(report_count), 32'd1);
    check("cr_deadlock", 32'(deadlock), 32'd0);

    // enable drop mid-CONFIRM (cnt = 2) and in REPORT.
    run_raw(2);
    check("ed_confirm", 32'(state), 32'd2);
    enable = 1'b0;
    tick();
    check("ed_disarmed", 32'(state), 32'd0);
    check("ed_no_glitch", 32'(glitch_count), 32'd0);
    enable = 1'b1;
    tick();
    run_raw(4);
    enable = 1'b0;
    tick();
    check("ed_report_stays", 32'(state), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ed_clear_disarm", 32'(state), 32'd0);

    // Glitches: 3 high then 1 low, 300 times.
    enable = 1'b1; raw_block = 1'b0;
    tick();
    seen_valid = 1'b0;
    for (int r = 0; r < 300; r++) begin
      for (int j = 0; j < 4; j++) begin
        raw_block = (j < 3);
        tick();
        if (rpt.report_valid) seen_valid = 1'b1;
      end
    end
    check("gl_no_valid", 32'(seen_valid), 32'd0);
    check("gl_sat", 32'(glitch_count), 32'd255);
    check("gl_model_sat", 32'(m_glitch), 32'd255);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(99) == 0);
      enable = ($urandom_range(19) != 0);
      clear = ($urandom_range(24) == 0);
      raw_block = ($urandom_range(7) != 0);
      rpt.report_ready = ($urandom_range(2) == 0);
      idle_vec = NP'($urandom);
      chan_block_vec = NP'($urandom);
      axis_block_vec = NP'($urandom);
      tick();
    end

    // Reset while in REPORT after a report and a glitch.
    reset = 1'b1; clear = 1'b0; rpt.report_ready = 1'b0; raw_block = 1'b0;
    tick();
    reset = 1'b0; enable = 1'b1;
    tick();
    raw_block = 1'b1;
    tick();
    raw_block = 1'b0;
    tick();
    idle_vec = 12'h123; chan_block_vec = 12'h450; axis_block_vec = 12'h00C;
    run_raw(4);
    rpt.report_ready = 1'b1;
    tick();
    rpt.report_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    run_raw(4);
    check("rr_in_report", 32'(state), 32'd3);
    check("rr_counts_set", {16'd0, glitch_count, report_count}, 32'h0101);
    reset = 1'b1;
    tick();
    check("rr_state", 32'(state), 32'd0);
    check("rr_flags", {30'd0, rpt.report_valid, deadlock}, 32'd0);
    check("rr_snap", {8'd0, rpt.report_stop_vec, rpt.report_axis_vec}, 32'd0);
    check("rr_nblk", 32'(rpt.report_nblk), 32'd0);
    check("rr_counts", {16'd0, glitch_count, report_count}, 32'd0);

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
